// File: rtl/matrix_3x3_gen.sv
// 3x3 pixel window generator: two line buffers plus a two-stage
// shift pipeline, zero-padded at the top and left borders.
module matrix_3x3_gen #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic       matrix_frame_vsync,
  output logic       matrix_frame_href,
  output logic       matrix_frame_clken,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33
);

  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [AW-1:0] COL_MAX = AW'(IMG_HDISP - 1);

  if (IMG_HDISP < 2 || IMG_VDISP < 1) begin : g_bad_geom
    $error("matrix_3x3_gen: bad image geometry");
  end

  logic          vsync_d;
  logic          href_d;
  logic          pix_vld;
  logic          vsync_rise;
  logic          href_fall;
  logic [AW-1:0] col;
  logic [1:0]    rows_seen;

  logic [7:0]    lb1 [IMG_HDISP];
  logic [7:0]    lb2 [IMG_HDISP];
  logic [7:0]    tap1;
  logic [7:0]    tap2;

  logic          s1_vld;
  logic          s1_first;
  logic [7:0]    s1_y;
  logic [7:0]    s1_t1;
  logic [7:0]    s1_t2;

  logic [2:0]    sync_d1;
  logic [2:0]    sync_d2;

  assign pix_vld    = per_frame_href & per_frame_clken;
  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign href_fall  = ~per_frame_href & href_d;

  assign tap1 = lb1[col];
  assign tap2 = lb2[col];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      col <= '0;
    else if (pix_vld)
      col <= (col == COL_MAX) ? '0 : col + 1'b1;
    else if (href_fall)
      col <= '0;
  end

  // A frame start overrides a line end landing in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rows_seen <= 2'd0;
    else if (vsync_rise)
      rows_seen <= 2'd0;
    else if (href_fall && !rows_seen[1])
      rows_seen <= rows_seen + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (pix_vld) begin
      lb1[col] <= per_img_Y;
      lb2[col] <= tap1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_y     <= '0;
      s1_t1    <= '0;
      s1_t2    <= '0;
    end else begin
      s1_vld <= pix_vld;
      if (pix_vld) begin
        s1_y     <= per_img_Y;
        s1_t1    <= (rows_seen != 2'd0) ? tap1 : 8'd0;
        s1_t2    <= rows_seen[1] ? tap2 : 8'd0;
        s1_first <= (col == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix_p11 <= '0;
      matrix_p12 <= '0;
      matrix_p13 <= '0;
      matrix_p21 <= '0;
      matrix_p22 <= '0;
      matrix_p23 <= '0;
      matrix_p31 <= '0;
      matrix_p32 <= '0;
      matrix_p33 <= '0;
    end else if (s1_vld) begin
      if (s1_first) begin
        matrix_p11 <= '0;
        matrix_p12 <= '0;
        matrix_p21 <= '0;
        matrix_p22 <= '0;
        matrix_p31 <= '0;
        matrix_p32 <= '0;
      end else begin
        matrix_p11 <= matrix_p12;
        matrix_p12 <= matrix_p13;
        matrix_p21 <= matrix_p22;
        matrix_p22 <= matrix_p23;
        matrix_p31 <= matrix_p32;
        matrix_p32 <= matrix_p33;
      end
      matrix_p13 <= s1_t2;
      matrix_p23 <= s1_t1;
      matrix_p33 <= s1_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d1 <= '0;
      sync_d2 <= '0;
    end else begin
      sync_d1 <= {per_frame_vsync, per_frame_href, per_frame_clken};
      sync_d2 <= sync_d1;
    end
  end

  assign matrix_frame_vsync = sync_d2[2];
  assign matrix_frame_href  = sync_d2[1];
  assign matrix_frame_clken = sync_d2[0];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Scoreboard bench for matrix_3x3_gen: directed frames then random
// frames, checked against a column-history reference model.
module tb_matrix_3x3_gen;

  localparam int H = 4;
  localparam int V = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vs  = 1'b0;
  logic       hr  = 1'b0;
  logic       ck  = 1'b0;
  logic [7:0] y   = 8'd0;

  logic       mv, mh, mc;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  matrix_3x3_gen #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk                (clk),
    .rst                (rst),
    .per_frame_vsync    (vs),
    .per_frame_href     (hr),
    .per_frame_clken    (ck),
    .per_img_Y          (y),
    .matrix_frame_vsync (mv),
    .matrix_frame_href  (mh),
    .matrix_frame_clken (mc),
    .matrix_p11         (p11),
    .matrix_p12         (p12),
    .matrix_p13         (p13),
    .matrix_p21         (p21),
    .matrix_p22         (p22),
    .matrix_p23         (p23),
    .matrix_p31         (p31),
    .matrix_p32         (p32),
    .matrix_p33         (p33)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    int          tag;
    bit          has_lit;
    logic [71:0] lit;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [2:0]  ins [int];
  logic [2:0]  es;
  logic [71:0] last_win = '0;

  // reference model state
  int          m_col = 0;
  int          m_rows = 0;
  bit          m_pvs = 0;
  bit          m_phr = 0;
  logic [7:0]  last1 [H];
  logic [7:0]  last2 [H];
  logic [23:0] prev1 = '0;
  logic [23:0] prev2 = '0;

  function automatic logic [71:0] dut_win();
    return {p11, p12, p13, p21, p22, p23, p31, p32, p33};
  endfunction

  function automatic logic [71:0] w9(int a, int b, int c, int d,
                                     int f, int g, int h, int i, int j);
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(f), 8'(g), 8'(h), 8'(i), 8'(j)};
  endfunction

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Window = three columns; each column is {two lines up, one up, current}
  // taken from what was last written at that column, masked near the top.
  task automatic model_step(bit v, bit h, bit c, logic [7:0] d,
                            output bit val, output logic [71:0] w);
    bit          vrise, hfall;
    logic [7:0]  t1, t2;
    logic [23:0] cur, c1, c2;
    vrise = v && !m_pvs;
    hfall = !h && m_phr;
    val = h && c;
    w = '0;
    if (val) begin
      t1 = (m_rows >= 1) ? last1[m_col] : 8'd0;
      t2 = (m_rows >= 2) ? last2[m_col] : 8'd0;
      cur = {t2, t1, d};
      c2 = (m_col >= 1) ? prev1 : 24'd0;
      c1 = (m_col >= 2) ? prev2 : 24'd0;
      w = {c1[23:16], c2[23:16], cur[23:16],
           c1[15:8],  c2[15:8],  cur[15:8],
           c1[7:0],   c2[7:0],   cur[7:0]};
      prev2 = prev1;
      prev1 = cur;
      last2[m_col] = last1[m_col];
      last1[m_col] = d;
      m_col = (m_col + 1) % H;
    end else if (hfall) begin
      m_col = 0;
    end
    if (vrise)
      m_rows = 0;
    else if (hfall && m_rows < 2)
      m_rows++;
    m_pvs = v;
    m_phr = h;
  endtask

  task automatic drive(bit v, bit h, bit c, logic [7:0] d,
                       bit hl = 0, logic [71:0] l = '0);
    bit          val;
    logic [71:0] w;
    exp_t        x;
    @(negedge clk);
    vs = v; hr = h; ck = c; y = d;
    model_step(v, h, c, d, val, w);
    if (val) begin
      x.win = w; x.tag = cyc + 2; x.has_lit = hl; x.lit = l;
      sb.push_back(x);
    end
  endtask

  task automatic vpulse();
    drive(1, 0, 0, 8'd0);
    drive(0, 0, 0, 8'd0);
  endtask

  task automatic line_end(bit vs_end);
    drive(vs_end, 0, 1, 8'hAA);
    drive(0, 0, 0, 8'h00);
  endtask

  task automatic dline(int base, int n, bit alt, bit vs_end,
                       int ia = -1, logic [71:0] la = '0,
                       int ib = -1, logic [71:0] lb = '0);
    for (int k = 0; k < n; k++) begin
      drive(0, 1, 1, 8'(base + k), (k == ia) || (k == ib),
            (k == ia) ? la : lb);
      if (alt && k < n - 1) drive(0, 1, 0, 8'hEE);
    end
    line_end(vs_end);
  endtask

  task automatic rline(int n, bit vs_end);
    int k = 0;
    bit c;
    while (k < n) begin
      c = ($urandom % 3) != 0;
      drive(0, 1, c, 8'($urandom));
      if (c) k++;
    end
    drive(vs_end, 0, 1'($urandom % 2), 8'($urandom));
    repeat ($urandom_range(0, 2))
      drive(0, 0, 1'($urandom % 2), 8'($urandom));
  endtask

  task automatic model_reset();
    sb.delete();
    last_win = '0;
    m_col = 0; m_rows = 0; m_pvs = 0; m_phr = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    ins[cyc] = {vs, hr, ck};
  end

  always @(negedge clk) begin
    if (!rst) begin
      es = ins.exists(cyc - 1) ? ins[cyc - 1] : 3'b000;
      chk("sync_delay", 80'({mv, mh, mc}), 80'(es));
      if (mc && mh) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_window at cycle %0d: got %h, expected none",
                   cyc, dut_win());
        end else begin
          e = sb.pop_front();
          chk("window", 80'(dut_win()), 80'(e.win));
          chk("latency", 80'(cyc), 80'(e.tag));
          if (e.has_lit) chk("scenario", 80'(dut_win()), 80'(e.lit));
          last_win = e.win;
        end
      end else begin
        chk("hold", 80'(dut_win()), 80'(last_win));
      end
    end
  end

  initial begin
    bit vend;
    #1 rst = 1'b1;
    #1 chk("reset_out", 80'({dut_win(), mv, mh, mc}), 80'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // frame 1: contiguous row0, strobed row1, contiguous row2
    drive(0, 0, 0, 8'd0);
    vpulse();
    dline(1, 4, 0, 0, 3, w9(0, 0, 0, 0, 0, 0, 2, 3, 4));
    dline(11, 4, 1, 0, 2, w9(0, 0, 0, 1, 2, 3, 11, 12, 13));
    dline(21, 4, 0, 0, 1, w9(0, 1, 2, 0, 11, 12, 0, 21, 22));

    // frame 2: stale buffers must stay masked
    vpulse();
    dline(101, 4, 0, 0, 1, w9(0, 0, 0, 0, 0, 0, 0, 101, 102));

    // frame 3: six pixels under one href, wrapping the column
    vpulse();
    dline(201, 6, 0, 0, 4, w9(0, 0, 0, 0, 0, 0, 0, 0, 205),
          5, w9(0, 0, 0, 0, 0, 0, 0, 205, 206));

    // frame 4: reset in the middle of row1
    vpulse();
    dline(1, 4, 0, 0);
    drive(0, 1, 1, 8'd11);
    drive(0, 1, 1, 8'd12);
    drive(0, 1, 1, 8'd13);
    @(posedge clk);
    #2 rst = 1'b1;
    vs = 0; hr = 0; ck = 0; y = 0;
    #1 chk("reset_mid", 80'({dut_win(), mv, mh, mc}), 80'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // frame 5: top-of-frame after reset, then vsync on the href fall
    vpulse();
    dline(31, 4, 0, 0, 3, w9(0, 0, 0, 0, 0, 0, 32, 33, 34));
    dline(41, 4, 0, 1, 3, w9(0, 0, 0, 32, 33, 34, 42, 43, 44));
    dline(51, 4, 0, 0, 3, w9(0, 0, 0, 0, 0, 0, 52, 53, 54));
    dline(61, 4, 0, 0, 3, w9(0, 0, 0, 52, 53, 54, 62, 63, 64));

    // random frames
    vpulse();
    for (int f = 0; f < 8; f++) begin
      for (int r = 0; r < V; r++) begin
        vend = (r == V - 1) && (($urandom % 2) != 0);
        rline($urandom_range(H, H + 2), vend);
        if (r == V - 1 && !vend) vpulse();
      end
    end

    repeat (6) drive(0, 0, 0, 8'd0);
    chk("drain", 80'(sb.size()), 80'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_3x3_gen.md
MATRIX_3X3_GEN -- requirements
Module: matrix_3x3_gen

Interface
REQ-001 The block SHALL take parameter IMG_HDISP, default 640: active pixels per line, which is also the line-buffer depth.
REQ-002 The block SHALL take parameter IMG_VDISP, default 480: active lines per frame, used for documentation and bench sizing only.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 per_frame_vsync  input  1  input frame sync; a rising edge marks frame start.
REQ-006 per_frame_href  input  1  input line valid.
REQ-007 per_frame_clken  input  1  input pixel strobe; a pixel is valid only when href=1 and clken=1.
REQ-008 per_img_Y  input  8  input pixel.
REQ-009 matrix_frame_vsync, matrix_frame_href, matrix_frame_clken  output  1 each  input syncs delayed 2 clk.
REQ-010 matrix_p11..p13, p21..p23, p31..p33  output  8 each  3x3 window, with row 1 = two lines up, row 3 = current line, column 3 = newest pixel.

Function
REQ-011 Column counter col SHALL increment on each valid pixel and wrap from IMG_HDISP-1 to 0, even if href stays high.
REQ-012 col SHALL be cleared to 0 on the href falling edge.
REQ-013 Two line buffers, lb1 and lb2, each IMG_HDISP x 8 and addressed by col, SHALL update on each valid pixel as follows:
- read tap1=lb1[col] and tap2=lb2[col];
- write lb1[col]<=per_img_Y and lb2[col]<=old lb1[col] in the same cycle.
REQ-014 rows_seen (2 bits) SHALL count completed lines (href falling edges), saturating at 2.
REQ-015 rows_seen SHALL be cleared on the vsync rising edge.
REQ-016 Tap masking: tap1 SHALL be forced to 0 when rows_seen<1, and tap2 SHALL be forced to 0 when rows_seen<2; line-buffer contents are never cleared.
REQ-017 Stage 1, the cycle after a valid pixel, SHALL register {per_img_Y, masked tap1, masked tap2, first=(col==0)}.
REQ-018 Stage 2 SHALL shift the window by one column, older columns first:
- p?1<=p?2, p?2<=p?3;
- p33<=pixel, p23<=tap1, p13<=tap2.
REQ-019 If first=1, stage 2 SHALL instead load p?1=p?2=0 (left border zero) while still loading column 3.
REQ-020 Latency SHALL be exactly 2 clk from a valid input pixel to matrix_frame_clken=1 with the corresponding window on matrix_p*.
REQ-021 matrix_frame_vsync, matrix_frame_href and matrix_frame_clken SHALL be per_frame_* through a 2-stage delay, with no gating.
REQ-022 The window SHALL update only on valid pixels and hold its value otherwise.
REQ-023 clken=1 with href=0 SHALL be ignored: no counter, buffer or window change.
REQ-024 If a vsync rising edge and an href falling edge occur in the same cycle, the vsync clear SHALL win and rows_seen=0.
REQ-025 The top border (rows above the frame) and the left border SHALL read 0; there is no right-border padding.

Reset
REQ-026 While rst=1, all outputs SHALL be 0: every matrix_p* = 0 and all three matrix_frame_* = 0.
REQ-027 While rst=1, col, rows_seen, the pipeline registers and the sync edge detectors SHALL be 0.
REQ-028 Line-buffer RAM SHALL not be reset.
REQ-029 Reset mid-frame SHALL abort the current frame; after release, masking SHALL treat the next lines as top-of-frame.

Verification
REQ-030 Bench parameters SHALL be IMG_HDISP=4, IMG_VDISP=3, with pixel = 10*row+col+1, i.e. row0 = 1..4, row1 = 11..14, row2 = 21..24.
REQ-031 The bench SHALL cover the following scenarios:
- Row0, col3 input (4) -> 2 clk later, matrix_frame_clken=1, p31/p32/p33 = 2/3/4, all other p = 0.
- Row2, col1 input (22) -> p11..p13 = 0/1/2, p21..p23 = 0/11/12, p31..p33 = 0/21/22.
- Clken asserted every other cycle during row1 -> same window values as with contiguous clken; matrix_frame_clken pulses exactly 2 clk after each input strobe; window holds between strobes.
- Second frame (vsync rising, then row0 = 101..104) -> at col1: p31..p33 = 0/101/102, rows 1-2 = 0 despite stale buffer data.
- href held for 6 valid pixels (A..F) -> pixel E lands at col0: p31=p32=0, p33=E; F gives 0/E/F.
- rst pulsed during row1, col2 -> all outputs 0 within the same cycle; next frame's row0 windows have rows 1-2 = 0.
